motor_speed_ramp: RTL and testbench
===================================

Name: motor_speed_ramp

Overview:
- Soft-start/soft-stop command stage directly upstream of the PWM motor driver.
- Accepts a target speed command over a valid/ready handshake.
- Slews its duty_cycle output toward the target one step per STEP_TICKS clocks and drives the driver's enable input.
- Duty is in percent (0..100); the driver runs slower at higher duty, so DUTY_STOP = 100 is the motor-at-rest value.

Parameters:
- STEP_TICKS, 500000, clocks between ramp steps (10 ms at 50 MHz); legal range 1..2^24-1.
- STEP_SIZE, 1, duty percent change per step; legal range 1..100.
- DUTY_STOP, 100, duty value output while stopped or idle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_run  input  1  1 = run at cmd_duty; 0 = ramp to stop.
- cmd_duty  input  8  target duty percent; values >100 are clamped to 100.
- estop  input  1  emergency stop, level-sensitive.
- duty_cycle  output  8  duty command to the motor driver.
- en  output  1  motor enable to the motor driver.
- busy  output  1  high while ramping.
- at_target  output  1  duty_cycle equals the latched target.

Behaviour:
- Reset (async, rst=1):
  - state IDLE, duty_cycle=DUTY_STOP, target=DUTY_STOP, run=0, tick=0.
  - Outputs: en=0, cmd_ready=1, busy=0, at_target=1.
- All outputs are registered or decoded directly from state/registers. No combinational path from cmd_* to outputs except cmd_ready, which depends on estop.
- States: IDLE, RAMP, HOLD, STOP.
- cmd_ready = !estop && state != STOP.
- Accept occurs when cmd_valid && cmd_ready. On the accepting edge:
  - target <= cmd_run ? min(cmd_duty,100) : DUTY_STOP.
  - run <= cmd_run; tick <= 0.
  - If cmd_run=1: en <= 1.
  - Next state is RAMP if the new target != duty_cycle. Otherwise it is HOLD (run=1) or IDLE with en <= 0 (run=0).
- Commands are accepted in IDLE, RAMP and HOLD. A retarget in mid-ramp restarts tick, and the ramp continues from the current duty_cycle with no jump.
- Ramp steps (RAMP state only):
  - tick counts 0..STEP_TICKS-1. On the edge where tick == STEP_TICKS-1, tick <= 0 and duty_cycle moves toward target by STEP_SIZE.
  - The step is computed in 9 bits and saturates at target: never overshoots, never wraps below 0 or above 100.
  - Latency from accept to the first duty change is exactly STEP_TICKS clocks.
- Ramp completion: on the edge where duty_cycle becomes equal to target:
  - run=1 -> state HOLD.
  - run=0 -> state IDLE and en <= 0 on that same edge.
- A command accept and a step tick on the same edge: the command wins, the step is suppressed and tick restarts at 0.
- HOLD: duty_cycle is constant and en=1. Wait for a command.
- estop (highest priority, any state):
  - On the next edge: state STOP, duty_cycle <= DUTY_STOP, en <= 0, target <= DUTY_STOP, run <= 0, tick <= 0.
  - The stop is immediate, with no ramp.
  - cmd_ready=0 combinationally while estop=1.
  - A command presented with estop=1 is not accepted.
- STOP: remain while estop=1. On the first edge with estop=0 -> IDLE, and cmd_ready returns to 1.
- Status outputs: busy = (state==RAMP); at_target = (duty_cycle==target).
- Reset asserted mid-ramp: all registers return to reset values immediately, asynchronously.

Test Plan:
- Common settings: STEP_TICKS=4, STEP_SIZE=5, DUTY_STOP=100.
- Reset then idle 20 clocks -> duty_cycle=100, en=0, cmd_ready=1, busy=0, at_target=1 throughout.
- Accept {run=1, duty=80} -> en=1 the edge after accept. duty_cycle 100→95→90→85→80, one step every 4 clocks, first step 4 clocks after accept. Then HOLD, busy=0, at_target=1.
- From HOLD at 80, accept {run=0}:
  - duty ramps 80→100 in steps of 5.
  - en falls on the same edge duty_cycle reaches 100; state IDLE.
- cmd_duty=200 with run=1, and STEP_SIZE=7 from duty 100 toward target 20:
  - cmd_duty=200 is clamped to target 100 and goes straight to HOLD.
  - Toward 20: sequence 93,86,79,72,65,58,51,44,37,30,23,20, with no undershoot.
- Mid-ramp at duty 90 (target 60), accept {run=1, duty=95} on a tick edge:
  - No step that edge.
  - Next step occurs 4 clocks later and goes to 95, then HOLD.
- estop pulse mid-ramp: one edge later duty_cycle=100, en=0, cmd_ready=0. A cmd_valid held during estop is ignored. On release -> IDLE and cmd_ready=1. Async rst during a ramp clears all outputs to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/motor_speed_ramp.sv
// Soft-start/soft-stop ramp for a PWM motor driver. It slews duty_cycle toward a
// commanded target one step every STEP_TICKS clocks, and estop forces an immediate stop.
module motor_speed_ramp #(
    parameter int unsigned STEP_TICKS = 500000,
    parameter int unsigned STEP_SIZE  = 1,
    parameter int unsigned DUTY_STOP  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_run,
    input  logic [7:0] cmd_duty,
    input  logic       estop,
    output logic [7:0] duty_cycle,
    output logic       en,
    output logic       busy,
    output logic       at_target
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

    localparam logic [23:0] TICK_LAST = 24'(STEP_TICKS - 1);
    localparam logic [8:0]  STEP9     = 9'(STEP_SIZE);
    localparam logic [7:0]  STOP_DUTY = 8'(DUTY_STOP);
    localparam logic [7:0]  DUTY_MAX  = 8'd100;

    state_t      state, state_n;
    logic [7:0]  target, target_n;
    logic [7:0]  duty_n;
    logic        run, run_n;
    logic        en_n;
    logic [23:0] tick, tick_n;

    logic        accept;
    logic [7:0]  cmd_target;
    logic [7:0]  step_duty;
    logic [8:0]  duty9, target9;

    assign cmd_ready  = !estop && (state != STOP);
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_target = cmd_run ? ((cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty) : STOP_DUTY;
    assign busy       = (state == RAMP);
    assign at_target  = (duty_cycle == target);

    assign duty9   = {1'b0, duty_cycle};
    assign target9 = {1'b0, target};

    // The step saturates at target, so it cannot overshoot or wrap past 0 or 100.
    always_comb begin
        step_duty = target;
        if (duty9 < target9) begin
            if (duty9 + STEP9 < target9)
                step_duty = 8'(duty9 + STEP9);
        end else if (duty9 > target9) begin
            if (duty9 > target9 + STEP9)
                step_duty = 8'(duty9 - STEP9);
        end
    end

    // NOTE: every next-value signal is given a hold default first, so no latch can be inferred.
    always_comb begin
        state_n  = state;
        target_n = target;
        duty_n   = duty_cycle;
        run_n    = run;
        en_n     = en;
        tick_n   = tick;

        if (estop) begin
            state_n  = STOP;
            duty_n   = STOP_DUTY;
            en_n     = 1'b0;
            target_n = STOP_DUTY;
            run_n    = 1'b0;
            tick_n   = '0;
        end else if (state == STOP) begin
            state_n = IDLE;
        end else if (accept) begin
            // A new command takes priority over a pending step, and the step interval restarts.
            target_n = cmd_target;
            run_n    = cmd_run;
            tick_n   = '0;
            if (cmd_run)
                en_n = 1'b1;
            if (cmd_target != duty_cycle) begin
                state_n = RAMP;
            end else if (cmd_run) begin
                state_n = HOLD;
            end else begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        end else if (state == RAMP) begin
            if (tick == TICK_LAST) begin
                tick_n = '0;
                duty_n = step_duty;
                if (step_duty == target) begin
                    if (run) begin
                        state_n = HOLD;
                    end else begin
                        state_n = IDLE;
                        en_n    = 1'b0;
                    end
                end
            end else begin
                tick_n = tick + 24'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= STOP_DUTY;
            target     <= STOP_DUTY;
            run        <= 1'b0;
            en         <= 1'b0;
            tick       <= '0;
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            target     <= target_n;
            run        <= run_n;
            en         <= en_n;
            tick       <= tick_n;
        end
    end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Scoreboard bench for motor_speed_ramp: expected duty changes are queued with their cycle
// stamp and checked by per-instance monitors, and status snapshots are checked inline.
module tb_motor_speed_ramp;

    typedef struct {
        int         cyc;
        logic [7:0] duty;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         vectors = 0;
    int         errors  = 0;

    logic       v5, run5, estop5, ready5, en5, busy5, at5;
    logic [7:0] d5, duty5;
    logic       v7, run7, estop7, ready7, en7, busy7, at7;
    logic [7:0] d7, duty7;

    exp_t       q5[$];
    exp_t       q7[$];
    logic [7:0] prev5 = 8'd100;
    logic [7:0] prev7 = 8'd100;

    motor_speed_ramp #(.STEP_TICKS(4), .STEP_SIZE(5), .DUTY_STOP(100)) dut (
        .clk(clk), .rst(rst), .cmd_valid(v5), .cmd_ready(ready5), .cmd_run(run5),
        .cmd_duty(d5), .estop(estop5), .duty_cycle(duty5), .en(en5), .busy(busy5),
        .at_target(at5)
    );

    motor_speed_ramp #(.STEP_TICKS(4), .STEP_SIZE(7), .DUTY_STOP(100)) dut7 (
        .clk(clk), .rst(rst), .cmd_valid(v7), .cmd_ready(ready7), .cmd_run(run7),
        .cmd_duty(d7), .estop(estop7), .duty_cycle(duty7), .en(en7), .busy(busy7),
        .at_target(at7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk5(input string n, input logic [7:0] d, input logic e, r, b, t);
        check(n, {20'd0, duty5, en5, ready5, busy5, at5}, {20'd0, d, e, r, b, t});
    endtask

    task automatic chk7(input string n, input logic [7:0] d, input logic e, r, b, t);
        check(n, {20'd0, duty7, en7, ready7, busy7, at7}, {20'd0, d, e, r, b, t});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge; acc returns the cycle number of the accepting edge.
    task automatic send(input bit sel, input logic run, input logic [7:0] duty, output int acc);
        if (sel) begin v7 = 1'b1; run7 = run; d7 = duty; end
        else     begin v5 = 1'b1; run5 = run; d5 = duty; end
        @(posedge clk);
        #1;
        acc = cyc;
        v5 = 1'b0;
        v7 = 1'b0;
    endtask

    task automatic push5(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.duty = d;
        q5.push_back(e);
    endtask

    task automatic push7(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.duty = d;
        q7.push_back(e);
    endtask

    always @(negedge clk) begin
        if (duty5 !== prev5) begin
            if (q5.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL dut5 unexpected duty change: got %0d, previous %0d (cycle %0d)", duty5, prev5, cyc);
            end else begin
                check("dut5 duty value", {24'd0, duty5}, {24'd0, q5[0].duty});
                check("dut5 duty cycle stamp", cyc, q5[0].cyc);
                void'(q5.pop_front());
            end
            prev5 <= duty5;
        end
    end

    always @(negedge clk) begin
        if (duty7 !== prev7) begin
            if (q7.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL dut7 unexpected duty change: got %0d, previous %0d (cycle %0d)", duty7, prev7, cyc);
            end else begin
                check("dut7 duty value", {24'd0, duty7}, {24'd0, q7[0].duty});
                check("dut7 duty cycle stamp", cyc, q7[0].cyc);
                void'(q7.pop_front());
            end
            prev7 <= duty7;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq7 [12];
        int a, b;
        seq7 = '{8'd93, 8'd86, 8'd79, 8'd72, 8'd65, 8'd58, 8'd51, 8'd44, 8'd37, 8'd30, 8'd23, 8'd20};

        rst = 1'b1;
        v5 = 1'b0; run5 = 1'b0; d5 = 8'd0; estop5 = 1'b0;
        v7 = 1'b0; run7 = 1'b0; d7 = 8'd0; estop7 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            chk5("idle after reset", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);
            wait_cycles(1);
        end

        // Step of 7 toward 20 saturates on the last step instead of undershooting.
        send(1'b1, 1'b1, 8'd20, a);
        chk7("dut7 accept", 8'd100, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) push7(a + 4 * k, seq7[k-1]);
        wait_cycles(48);
        chk7("dut7 hold at 20", 8'd20, 1'b1, 1'b1, 1'b0, 1'b1);

        // Run to 80.
        send(1'b0, 1'b1, 8'd80, a);
        chk5("accept run 80", 8'd100, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) push5(a + 4 * k, 8'(100 - 5 * k));
        wait_cycles(16);
        chk5("hold at 80", 8'd80, 1'b1, 1'b1, 1'b0, 1'b1);

        // Ramp to stop; en falls on the edge duty reaches 100.
        send(1'b0, 1'b0, 8'd0, a);
        for (int k = 1; k <= 4; k++) push5(a + 4 * k, 8'(80 + 5 * k));
        wait_cycles(15);
        chk5("stop ramp before last step", 8'd95, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_cycles(1);
        chk5("stop ramp reaches idle", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);

        // Oversized duty clamps to 100, which equals the current duty.
        send(1'b0, 1'b1, 8'd200, a);
        chk5("clamp to hold", 8'd100, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 8'd0, a);
        chk5("stop at rest to idle", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);

        // Retarget on a step edge: no step that edge, next step 4 clocks later.
        send(1'b0, 1'b1, 8'd60, a);
        push5(a + 4, 8'd95);
        push5(a + 8, 8'd90);
        wait_cycles(11);
        send(1'b0, 1'b1, 8'd95, b);
        chk5("retarget suppresses step", 8'd90, 1'b1, 1'b1, 1'b1, 1'b0);
        push5(b + 4, 8'd95);
        wait_cycles(3);
        chk5("retarget before step", 8'd90, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_cycles(1);
        chk5("retarget hold at 95", 8'd95, 1'b1, 1'b1, 1'b0, 1'b1);

        // Emergency stop mid-ramp with a command held on the port.
        send(1'b0, 1'b1, 8'd70, a);
        push5(a + 4, 8'd90);
        wait_cycles(5);
        estop5 = 1'b1; v5 = 1'b1; run5 = 1'b1; d5 = 8'd50;
        #1;
        chk5("estop drops ready", 8'd90, 1'b1, 1'b0, 1'b1, 1'b0);
        push5(a + 6, 8'd100);
        @(posedge clk);
        #1;
        chk5("estop immediate stop", 8'd100, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(3);
        chk5("estop held ignores cmd", 8'd100, 1'b0, 1'b0, 1'b0, 1'b1);
        estop5 = 1'b0; v5 = 1'b0;
        #1;
        chk5("estop released still stop", 8'd100, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk5("stop to idle", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);

        // Async reset between edges during a ramp.
        send(1'b0, 1'b1, 8'd50, a);
        push5(a + 4, 8'd95);
        wait_cycles(5);
        chk5("ramp before reset", 8'd95, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        push5(a + 5, 8'd100);
        push7(a + 5, 8'd100);
        rst = 1'b1;
        #1;
        chk5("async reset dut5", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);
        chk7("async reset dut7", 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);
        check("dut5 scoreboard drained", q5.size(), 0);
        check("dut7 scoreboard drained", q7.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
